// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage write scoreboard behind ID, RAW detection,
// stall/bubble/flush generation and optional operand-forward selects.
module pipe_hazard_ctrl #(
   parameter int N_STAGES       = 3,
   parameter int ADDR_W         = 5,
   parameter int FWD_EN         = 0,
   parameter int REDIRECT_STAGE = 1,
   parameter int CNT_W          = 16,
   parameter int SEL_W          = 2
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                enable,
   input  logic                id_valid,
   input  logic [ADDR_W-1:0]   id_raddr_1,
   input  logic [ADDR_W-1:0]   id_raddr_2,
   input  logic                id_uses_1,
   input  logic                id_uses_2,
   input  logic                id_reg_write,
   input  logic [ADDR_W-1:0]   id_waddr,
   input  logic                id_mem_read,
   input  logic                redirect,
   output logic                stall,
   output logic                bubble,
   output logic                flush_if_id,
   output logic [N_STAGES-1:0] stage_valid,
   output logic [SEL_W-1:0]    fwd_sel_1,
   output logic [SEL_W-1:0]    fwd_sel_2,
   output logic [CNT_W-1:0]    stall_count
);

   logic [N_STAGES-1:0] r_v;
   logic [N_STAGES-1:0] r_wr;
   logic [N_STAGES-1:0] r_ld;
   logic [ADDR_W-1:0]   r_wa [N_STAGES];
   logic [CNT_W-1:0]    r_cnt;

   logic [N_STAGES-1:0] w_m1;
   logic [N_STAGES-1:0] w_m2;
   logic [SEL_W-1:0]    w_sel_1;
   logic [SEL_W-1:0]    w_sel_2;
   logic                w_hz;

   // Register 0 is hardwired, so a pending write to it never creates a dependency.
   always_comb begin
      w_m1 = '0;
      w_m2 = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         w_m1[i] = r_v[i] & r_wr[i] & (r_wa[i] != '0) & (r_wa[i] == id_raddr_1)
                   & id_uses_1 & id_valid;
         w_m2[i] = r_v[i] & r_wr[i] & (r_wa[i] != '0) & (r_wa[i] == id_raddr_2)
                   & id_uses_2 & id_valid;
      end
   end

   // Scan oldest to youngest so the youngest producer wins.
   always_comb begin
      w_sel_1 = '0;
      w_sel_2 = '0;
      for (int i = N_STAGES - 1; i >= 0; i--) begin
         if (w_m1[i]) w_sel_1 = SEL_W'(i + 1);
         if (w_m2[i]) w_sel_2 = SEL_W'(i + 1);
      end
   end

   always_comb begin
      w_hz      = 1'b0;
      fwd_sel_1 = '0;
      fwd_sel_2 = '0;
      if (FWD_EN != 0) begin
         // Only a load sitting in EX cannot be forwarded in time.
         w_hz      = r_ld[0] & (w_m1[0] | w_m2[0]);
         fwd_sel_1 = w_sel_1;
         fwd_sel_2 = w_sel_2;
      end else begin
         w_hz      = |{w_m1, w_m2};
      end
   end

   assign stall       = w_hz & ~redirect;
   assign bubble      = w_hz | redirect;
   assign flush_if_id = redirect;
   assign stage_valid = r_v;
   assign stall_count = r_cnt;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_v   <= '0;
         r_wr  <= '0;
         r_ld  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < N_STAGES; i++) r_wa[i] <= '0;
      end else if (enable) begin
         r_v[0]  <= id_valid & ~w_hz & ~redirect;
         r_wr[0] <= id_reg_write;
         r_ld[0] <= id_mem_read;
         r_wa[0] <= id_waddr;
         // Everything younger than the resolving branch is on the wrong path.
         for (int i = 1; i < N_STAGES; i++) begin
            r_v[i]  <= r_v[i-1] & ~(redirect & (i <= REDIRECT_STAGE));
            r_wr[i] <= r_wr[i-1];
            r_ld[i] <= r_ld[i-1];
            r_wa[i] <= r_wa[i-1];
         end
         if (stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: interlock, forwarding and 4-bit-counter builds share one
// stimulus stream; each is checked against its own in-flight instruction model.
module tb_pipe_hazard_ctrl;

   localparam int RS = 1;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       enable;
   logic       id_valid;
   logic [4:0] id_raddr_1;
   logic [4:0] id_raddr_2;
   logic       id_uses_1;
   logic       id_uses_2;
   logic       id_reg_write;
   logic [4:0] id_waddr;
   logic       id_mem_read;
   logic       redirect;

   logic       st [3];
   logic       bb [3];
   logic       fl [3];
   logic [1:0] f1 [3];
   logic [1:0] f2 [3];
   logic [2:0] sv [3];
   logic [15:0] c0, c1;
   logic [3:0]  c2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FWD_EN(0)) u0 (
      .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
      .id_raddr_1(id_raddr_1), .id_raddr_2(id_raddr_2), .id_uses_1(id_uses_1),
      .id_uses_2(id_uses_2), .id_reg_write(id_reg_write), .id_waddr(id_waddr),
      .id_mem_read(id_mem_read), .redirect(redirect), .stall(st[0]), .bubble(bb[0]),
      .flush_if_id(fl[0]), .stage_valid(sv[0]), .fwd_sel_1(f1[0]), .fwd_sel_2(f2[0]),
      .stall_count(c0));

   pipe_hazard_ctrl #(.FWD_EN(1)) u1 (
      .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
      .id_raddr_1(id_raddr_1), .id_raddr_2(id_raddr_2), .id_uses_1(id_uses_1),
      .id_uses_2(id_uses_2), .id_reg_write(id_reg_write), .id_waddr(id_waddr),
      .id_mem_read(id_mem_read), .redirect(redirect), .stall(st[1]), .bubble(bb[1]),
      .flush_if_id(fl[1]), .stage_valid(sv[1]), .fwd_sel_1(f1[1]), .fwd_sel_2(f2[1]),
      .stall_count(c1));

   pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u2 (
      .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
      .id_raddr_1(id_raddr_1), .id_raddr_2(id_raddr_2), .id_uses_1(id_uses_1),
      .id_uses_2(id_uses_2), .id_reg_write(id_reg_write), .id_waddr(id_waddr),
      .id_mem_read(id_mem_read), .redirect(redirect), .stall(st[2]), .bubble(bb[2]),
      .flush_if_id(fl[2]), .stage_valid(sv[2]), .fwd_sel_1(f1[2]), .fwd_sel_2(f2[2]),
      .stall_count(c2));

   // ---------------- reference model: in-flight instructions by age ----------------
   typedef struct {
      bit         v;
      bit         wr;
      bit         ld;
      logic [4:0] wa;
   } ent_t;

   ent_t mp [3][3];
   int   mcnt [3];
   int   cmax [3] = '{65535, 65535, 15};
   bit   fwdp [3] = '{1'b0, 1'b1, 1'b0};

   function automatic void mdl_reset();
      for (int d = 0; d < 3; d++) begin
         mcnt[d] = 0;
         for (int i = 0; i < 3; i++) mp[d][i] = '{v: 1'b0, wr: 1'b0, ld: 1'b0, wa: 5'd0};
      end
   endfunction

   function automatic void mdl_comb(input int d, output bit hz, output bit [1:0] e1,
                                    output bit [1:0] e2);
      int y1 = -1;
      int y2 = -1;
      for (int i = 2; i >= 0; i--) begin
         if (mp[d][i].v && mp[d][i].wr && mp[d][i].wa != 5'd0 && id_valid) begin
            if (id_uses_1 && mp[d][i].wa == id_raddr_1) y1 = i;
            if (id_uses_2 && mp[d][i].wa == id_raddr_2) y2 = i;
         end
      end
      if (fwdp[d]) begin
         e1 = 2'(y1 + 1);
         e2 = 2'(y2 + 1);
         hz = ((y1 == 0) || (y2 == 0)) && mp[d][0].ld;
      end else begin
         e1 = 2'd0;
         e2 = 2'd0;
         hz = (y1 >= 0) || (y2 >= 0);
      end
   endfunction

   function automatic void mdl_next();
      bit hz;
      bit [1:0] e1, e2;
      if (!enable) return;
      for (int d = 0; d < 3; d++) begin
         mdl_comb(d, hz, e1, e2);
         for (int i = 2; i >= 1; i--) begin
            mp[d][i] = mp[d][i-1];
            if (redirect && i <= RS) mp[d][i].v = 1'b0;
         end
         mp[d][0] = '{v: id_valid && !hz && !redirect, wr: id_reg_write,
                      ld: id_mem_read, wa: id_waddr};
         if (hz && !redirect && mcnt[d] < cmax[d]) mcnt[d]++;
      end
   endfunction

   function automatic logic [15:0] cnt_of(input int d);
      case (d)
         0:       return c0;
         1:       return c1;
         default: return {12'd0, c2};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic mdl_check();
      bit hz;
      bit [1:0] e1, e2;
      logic [2:0] ev;
      logic [31:0] got, exp;
      for (int d = 0; d < 3; d++) begin
         mdl_comb(d, hz, e1, e2);
         for (int i = 0; i < 3; i++) ev[i] = mp[d][i].v;
         exp = {6'd0, hz && !redirect, hz || redirect, redirect, e1, e2, ev, 16'(mcnt[d])};
         got = {6'd0, st[d], bb[d], fl[d], f1[d], f2[d], sv[d], cnt_of(d)};
         chk($sformatf("mdl_u%0d", d), got, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                        input bit u2, input bit wr, input logic [4:0] wa, input bit ld,
                        input bit rd, input bit en);
      id_valid = v; id_raddr_1 = r1; id_uses_1 = u1; id_raddr_2 = r2; id_uses_2 = u2;
      id_reg_write = wr; id_waddr = wa; id_mem_read = ld; redirect = rd; enable = en;
   endtask

   task automatic settle();
      @(negedge clk);
      mdl_check();
   endtask

   task automatic advance();
      mdl_next();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit         v;
      logic [4:0] r1;
      bit         u1;
      bit         wr;
      logic [4:0] wa;
      bit         ld;
      bit         st0;
      bit         st1;
      logic [1:0] fs1;
   } vec_t;

   vec_t tbl [10];

   initial begin
      // add r3; three consumers of r3 (also forwarding-distance walk); load r5 + use; load r0 + use
      tbl[0] = '{1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 2'd1};
      tbl[2] = '{1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[3] = '{1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 2'd3};
      tbl[4] = '{1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[5] = '{1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[6] = '{1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 2'd1};
      tbl[7] = '{1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2};
      tbl[8] = '{1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0};
      tbl[9] = '{1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0};

      arst_n = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      mdl_reset();
      #2;
      for (int d = 0; d < 3; d++)
         chk($sformatf("rst_u%0d", d),
             {st[d], bb[d], fl[d], f1[d], f2[d], sv[d], cnt_of(d)}, 32'd0);
      #10 arst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 10; k++) begin
         drive(tbl[k].v, tbl[k].r1, tbl[k].u1, 5'd0, 1'b0, tbl[k].wr, tbl[k].wa, tbl[k].ld,
               1'b0, 1'b1);
         settle();
         chk($sformatf("tbl%0d_stall_ilk", k), 32'(st[0]), 32'(tbl[k].st0));
         chk($sformatf("tbl%0d_bubble_ilk", k), 32'(bb[0]), 32'(tbl[k].st0));
         chk($sformatf("tbl%0d_stall_fwd", k), 32'(st[1]), 32'(tbl[k].st1));
         chk($sformatf("tbl%0d_fwdsel1", k), 32'(f1[1]), 32'(tbl[k].fs1));
         advance();
      end
      chk("cnt_ilk_after_tbl", 32'(c0), 32'd5);
      chk("cnt_fwd_after_tbl", 32'(c1), 32'd1);

      // redirect while ID has a hazard
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
      cyc();
      chk("pre_redirect_valid", 32'(sv[0]), 32'h7);
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      settle();
      chk("redir_stall", 32'(st[0]), 32'd0);
      chk("redir_bubble", 32'(bb[0]), 32'd1);
      chk("redir_flush", 32'(fl[0]), 32'd1);
      advance();
      chk("redir_valid_after", 32'(sv[0]), 32'h4);
      chk("redir_cnt", 32'(c0), 32'd5);

      // freeze with a full scoreboard and a pending hazard, then async reset
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
         cyc();
      end
      chk("full_valid", 32'(sv[0]), 32'h7);
      drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         settle();
         chk($sformatf("frz%0d_stall", k), 32'(st[0]), 32'd1);
         chk($sformatf("frz%0d_valid", k), 32'(sv[0]), 32'h7);
         chk($sformatf("frz%0d_cnt", k), 32'(c0), 32'd5);
         advance();
      end
      #2 arst_n = 1'b0;
      #1;
      chk("arst_stall", 32'(st[0]), 32'd0);
      chk("arst_valid", 32'(sv[0]), 32'd0);
      chk("arst_cnt", 32'(c0), 32'd0);
      chk("arst_cnt_small", 32'(c2), 32'd0);
      mdl_reset();
      #2 arst_n = 1'b1;
      @(posedge clk);
      #1;

      // counter saturation on the 4-bit build: each producer/consumer pair costs 3 stalls
      for (int it = 0; it < 6; it++) begin
         drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
         cyc();
         drive(1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         for (int k = 0; k < 4; k++) cyc();
         if (it == 4) begin
            chk("sat_small_15", 32'(c2), 32'd15);
            chk("sat_wide_15", 32'(c0), 32'd15);
         end
      end
      chk("sat_small_hold", 32'(c2), 32'd15);
      chk("sat_wide_18", 32'(c0), 32'd18);

      // randomized traffic with small address space to force collisions
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) != 0));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
